// File: rtl/recv_pkg.sv
// Shared widths and word type for the UART receive path and the datapath register-write mux.
package recv_pkg;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/word_fifo.sv
// Circular word FIFO with extra-MSB pointers, registered level and synchronous flush.
module word_fifo
  import recv_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter type data_t = word_t,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  data_t       wdata,
  output data_t       rdata,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level
);

  data_t       mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    do_pop  = pop & ~empty & ~flush;
    // A push into a full FIFO only lands when the same-cycle pop frees a slot.
    do_push = push & (~full | do_pop) & ~flush;
    rdata   = empty ? '0 : mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/recv_word_buffer.sv
// Packs little-endian UART bytes into 32-bit words and queues them for readi/readf.
module recv_word_buffer
  import recv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [BYTE_W-1:0]        rx_data,
  input  logic                     rx_valid,
  input  logic                     recv_pop,
  input  logic                     flush,
  output logic                     recv_valid,
  output word_t                    recv_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               byte_phase,
  output logic                     overflow
);

  localparam int HOLD_W = (BYTES_PER_WORD - 1) * BYTE_W;

  logic [HOLD_W-1:0] hold;
  logic              word_done;
  logic              fifo_empty;
  logic              fifo_full;
  word_t             word;

  always_comb begin
    word_done  = rx_valid & ~flush & (byte_phase == 2'(BYTES_PER_WORD - 1));
    word       = {rx_data, hold};
    recv_valid = ~fifo_empty;
  end

  // Bytes shift in from the top so the oldest ends up in [7:0] when the word closes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold       <= '0;
      byte_phase <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      byte_phase <= '0;
      overflow   <= 1'b0;
    end else begin
      if (rx_valid) begin
        hold       <= {rx_data, hold[HOLD_W-1:BYTE_W]};
        byte_phase <= byte_phase + 2'd1;
      end
      if (word_done && fifo_full && !recv_pop) overflow <= 1'b1;
    end
  end

  word_fifo #(
    .DEPTH  (DEPTH),
    .data_t (word_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (word_done),
    .pop   (recv_pop),
    .wdata (word),
    .rdata (recv_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

endmodule

// File: tb/tb_recv_word_buffer.sv
// Scoreboard bench for recv_word_buffer: expected words queued at the 4th byte, checked at pop.
module tb_recv_word_buffer;
  import recv_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        recv_pop = 1'b0;
  logic        flush = 1'b0;
  logic        recv_valid;
  word_t       recv_data;
  logic [4:0]  level;
  logic [1:0]  byte_phase;
  logic        overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  word_t       sb[$];
  logic [23:0] m_hold;
  int unsigned m_phase;
  logic        m_ovf;

  recv_word_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .recv_pop   (recv_pop),
    .flush      (flush),
    .recv_valid (recv_valid),
    .recv_data  (recv_data),
    .level      (level),
    .byte_phase (byte_phase),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_hold  = '0;
    m_phase = 0;
    m_ovf   = 1'b0;
    sb.delete();
  endtask

  // One clock: drive inputs, take the edge, update the reference model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic p, input logic f);
    bit pe;
    rx_valid = v; rx_data = d; recv_pop = p; flush = f;
    @(posedge clk); #1;
    rx_valid = 1'b0; recv_pop = 1'b0; flush = 1'b0;
    if (f) begin
      model_clear();
    end else begin
      pe = p && (sb.size() > 0);
      if (pe) void'(sb.pop_front());
      if (v) begin
        if (m_phase == 3) begin
          if (sb.size() < DEPTH) sb.push_back({d, m_hold});
          else m_ovf = 1'b1;
          m_phase = 0;
        end else begin
          m_hold[m_phase*8 +: 8] = d;
          m_phase++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    model_clear();
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", recv_valid); end
    checks++; if (recv_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", recv_data); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (byte_phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", byte_phase); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
  endtask

  task automatic test_byte_order();
    logic [7:0] bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    logic [1:0] phases [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL order_early_valid[%0d] got %0b exp 0", i, recv_valid); end
      cyc(1'b1, bytes[i], 1'b0, 1'b0);
      checks++; if (byte_phase !== phases[i]) begin errors++; $display("FAIL order_phase[%0d] got %0d exp %0d", i, byte_phase, phases[i]); end
    end
    checks++; if (recv_valid !== 1'b1) begin errors++; $display("FAIL order_valid got %0b exp 1", recv_valid); end
    checks++; if (recv_data !== 32'h12345678) begin errors++; $display("FAIL order_data got %h exp 12345678", recv_data); end
    checks++; if (recv_data !== sb[0]) begin errors++; $display("FAIL order_sb got %h exp %h", recv_data, sb[0]); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL order_level_after_pop got %0d exp 0", level); end
  endtask

  task automatic test_sparse();
    logic [7:0] bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, bytes[i], 1'b0, 1'b0);
      repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checks++; if (recv_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sparse_data got %h exp deadbeef", recv_data); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL sparse_level got %0d exp 1", level); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL sparse_valid_after_pop got %0b exp 0", recv_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL sparse_level_after_pop got %0d exp 0", level); end
  endtask

  task automatic test_fill_overflow();
    for (int k = 1; k <= DEPTH + 1; k++)
      for (int j = 0; j < 4; j++) cyc(1'b1, 8'(k * 4 + j), 1'b0, 1'b0);
    checks++; if (level !== 5'(DEPTH)) begin errors++; $display("FAIL fill_level got %0d exp %0d", level, DEPTH); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %0b exp 1", overflow); end
    checks++; if (byte_phase !== 2'd0) begin errors++; $display("FAIL fill_phase got %0d exp 0", byte_phase); end
    for (int k = 1; k <= DEPTH; k++) begin
      checks++; if (recv_data !== sb[0]) begin errors++; $display("FAIL fill_pop[%0d] got %h exp %h", k, recv_data, sb[0]); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL fill_drained got %0b exp 0", recv_valid); end
  endtask

  task automatic test_full_boundary();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < 4; j++) cyc(1'b1, 8'(8'h80 + k * 4 + j), 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) cyc(1'b1, 8'(8'hC0 + j), 1'b0, 1'b0);
    checks++; if (level !== 5'(DEPTH)) begin errors++; $display("FAIL bound_full got %0d exp %0d", level, DEPTH); end
    checks++; if (recv_data !== sb[0]) begin errors++; $display("FAIL bound_head got %h exp %h", recv_data, sb[0]); end
    cyc(1'b1, 8'hC3, 1'b1, 1'b0);
    checks++; if (level !== 5'(DEPTH)) begin errors++; $display("FAIL bound_level got %0d exp %0d", level, DEPTH); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bound_ovf got %0b exp 0", overflow); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (recv_data !== sb[0]) begin errors++; $display("FAIL bound_pop[%0d] got %h exp %h", k, recv_data, sb[0]); end
      if (k == DEPTH - 1) begin
        checks++; if (recv_data !== 32'hC3C2C1C0) begin errors++; $display("FAIL bound_last got %h exp c3c2c1c0", recv_data); end
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_pop_empty();
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL popempty_level got %0d exp 0", level); end
    checks++; if (recv_data !== 32'h0) begin errors++; $display("FAIL popempty_data got %h exp 0", recv_data); end
    checks++; if (byte_phase !== 2'd1) begin errors++; $display("FAIL popempty_phase got %0d exp 1", byte_phase); end
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0, 1'b0);
    cyc(1'b1, 8'hA4, 1'b1, 1'b0);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL popempty_push_level got %0d exp 1", level); end
    checks++; if (recv_data !== 32'hA4A3A2A1) begin errors++; $display("FAIL popempty_word got %h exp a4a3a2a1", recv_data); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_flush_reset();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) cyc(1'b1, 8'(8'h10 + k * 4 + j), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
    checks++; if (byte_phase !== 2'd0) begin errors++; $display("FAIL flush_phase got %0d exp 0", byte_phase); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %0b exp 0", overflow); end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", recv_valid); end
    for (int j = 0; j < 4; j++) cyc(1'b1, 8'(8'h21 + j), 1'b0, 1'b0);
    checks++; if (recv_data !== 32'h24232221) begin errors++; $display("FAIL flush_clean got %h exp 24232221", recv_data); end
    cyc(1'b1, 8'h90, 1'b0, 1'b0);
    cyc(1'b1, 8'h91, 1'b0, 1'b0);
    rstn = 1'b0;
    #2;
    model_clear();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (byte_phase !== 2'd0) begin errors++; $display("FAIL rst_phase got %0d exp 0", byte_phase); end
    checks++; if (recv_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", recv_data); end
    @(posedge clk); #1 rstn = 1'b1;
    for (int j = 0; j < 4; j++) cyc(1'b1, 8'(8'h31 + j), 1'b0, 1'b0);
    checks++; if (recv_data !== 32'h34333231) begin errors++; $display("FAIL rst_clean got %h exp 34333231", recv_data); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) begin
      logic p;
      p = (sb.size() > 0);
      if (p) begin
        checks++; if (recv_data !== sb[0]) begin errors++; $display("FAIL b2b_pop[%0d] got %h exp %h", i, recv_data, sb[0]); end
      end
      cyc(1'b1, 8'($urandom_range(0, 255)), p, 1'b0);
    end
    checks++; if (level !== 5'(sb.size())) begin errors++; $display("FAIL b2b_level got %0d exp %0d", level, sb.size()); end
    while (sb.size() > 0) begin
      checks++; if (recv_data !== sb[0]) begin errors++; $display("FAIL b2b_drain got %h exp %h", recv_data, sb[0]); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", recv_valid); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_byte_order();
    test_sparse();
    test_fill_overflow();
    test_full_boundary();
    test_pop_empty();
    test_flush_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recv_word_buffer.md
# recv_word_buffer

Assembles the byte stream from the UART receiver into 32-bit words and buffers them for the CPU's `readi`/`readf` instructions. It sits directly upstream of the main decoder and datapath: its `recv_valid` drives the decoder's `recv_valid` input, which stalls a read while low. Its `recv_data` supplies the value written to the integer or FP register file. The CPU pops one word per completed read.

## Interface
- `DEPTH`, 16: word FIFO depth; power of two, at least 2.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `rx_data` input 8: received byte from UART receiver.
- `rx_valid` input 1: one-cycle strobe, `rx_data` valid.
- `recv_pop` input 1: CPU consumes head word (`readi`/`readf` retiring).
- `flush` input 1: synchronous clear of assembler, FIFO and overflow.
- `recv_valid` output 1: FIFO non-empty.
- `recv_data` output 32: head word; 0 when empty.
- `level` output $clog2(DEPTH)+1: words held, 0..DEPTH.
- `byte_phase` output 2: bytes of the partial word collected, 0..3.
- `overflow` output 1: sticky; a completed word was dropped because the FIFO was full.

## Operation
- **Assembler, byte order:** little-endian; the first byte of a word goes to [7:0], the fourth to [31:24].
- **Assembler, phase:** `byte_phase` increments on each accepted `rx_valid` and wraps 3→0. The 4th byte completes a word.
- **Assembler, push:** the completed word, including the byte arriving this cycle, is pushed in the same edge.
- **Assembler, partial bytes:** held in a 24-bit shift/hold register. No timeout; a partial word waits indefinitely.
- **FIFO:** circular buffer with read/write pointers one bit wider than the index. Full when the index bits are equal and the MSBs differ; empty when the pointers are equal.
- **Push when full, no pop in the same cycle:** the word is discarded, `overflow` is set, and `byte_phase` still wraps to 0.
- **Push and pop together when full:** both take effect; `level` is unchanged and `overflow` is not set.
- **Push and pop together when empty:** the pop is ignored and the push is taken; `level` becomes 1.
- **Pop while empty:** ignored, with no pointer change.
- **Flush:** `flush`=1 takes priority over `rx_valid` and `recv_pop`. It clears `byte_phase`, both pointers and `overflow`; the incoming byte that cycle is dropped.
- **Outputs:** `recv_data` is the FIFO head read combinationally from registered storage and pointer. It is forced to 0 when empty so an idle bus is deterministic.

## Timing
- **Reset values** (`rstn` low, asynchronous): `recv_valid`=0, `recv_data`=0, `level`=0, `byte_phase`=0, `overflow`=0. Pointers and the hold register are cleared.
- **Reset mid-word:** discards the partial bytes.
- **Storage array:** not reset.
- **Latency:** 4th `rx_valid` sampled at edge N → `recv_valid`=1 and `recv_data` valid after edge N, i.e. 1 cycle.
- **Pop:** `recv_pop` sampled at edge M with `recv_valid`=1 → after M, `recv_data` shows the next word, or `recv_valid` drops if that was the last word.
- **CPU obligation:** hold `recv_pop` high for exactly one cycle per consumed word. A stalled read keeps `recv_pop` low.
- **Throughput:** 1 byte/cycle in and 1 word/cycle out are sustained with no bubbles.
- **`level`:** registered, and consistent with the pointers every cycle.

## Structure
- **Package `recv_pkg`:** `BYTE_W`=8, `WORD_W`=32, `BYTES_PER_WORD`=4, and `typedef logic [WORD_W-1:0] word_t`. The datapath's register-write mux imports `word_t`.
- **Sub-module `word_fifo`:** parameterised by `DEPTH` and `word_t`. Ports are push, pop, wdata, rdata, empty, full, level and flush.
- **`recv_word_buffer` itself:** contains the byte assembler and the overflow flag.

## Test plan
- **Byte order:** bytes 0x78, 0x56, 0x34, 0x12 on consecutive cycles → `recv_valid` rises one cycle after the 4th byte; `recv_data`=0x12345678; `byte_phase` goes 1, 2, 3, 0.
- **Sparse bytes:** bytes 0xEF, 0xBE, 0xAD, 0xDE spread over 20 cycles, then pop → word 0xDEADBEEF; `recv_valid` falls after the pop edge and `level` returns to 0.
- **Fill and overflow:** 4×(`DEPTH`+1) bytes with no pops → `level`=16 and `overflow`=1. The 17th word is lost; popping 16 times returns words 1..16 in order.
- **Full boundary:** with the FIFO full, the 4th byte arrives in the same cycle as a pop → `level` stays 16, `overflow` stays 0, and the new word appears last.
- **Pop on empty:** `recv_pop` pulsed while empty → no state change, `recv_data`=0.
- **Flush and reset mid-operation:** flush asserted after 2 bytes with 3 words queued → `level`=0, `byte_phase`=0, `overflow`=0. The next 4 bytes form a clean word. `rstn` pulsed low mid-word gives the same result.
